machine_log_reader: RTL and testbench

//  Read-back side of the vending-machine log. Replays entries from the log RAM, oldest first,
//  as decoded fields. Optional filter on operator code. Sits between the log RAM read port
//  and the diagnostics/display path. The log writer owns the RAM write port and wr_ptr/wrapped.

---
 rtl/machine_log_reader_if.sv | 52 +++++
 rtl/machine_log_reader.sv | 137 +++++++++++++
 tb/tb_machine_log_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/machine_log_reader_if.sv
//------------------------------------------------------------------------------
// Module  : machine_log_reader_if
// Purpose : Bundles the replay control, log RAM read port and decoded-entry
//           output stream of machine_log_reader.
//   master : the reader itself (drives RAM read strobe/address and outputs)
//   slave  : the surroundings (control inputs, RAM data, consumer ready)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface machine_log_reader_if #(
  parameter int ADDR_W  = 4,
  parameter int ENTRY_W = 15
);
  // replay control and writer state
  logic                start;
  logic                filter_en;
  logic [1:0]          filter_op;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                wrapped;
  // log RAM read port
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [ENTRY_W-1:0]  mem_rd_data;
  // decoded entry stream
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_operator;
  logic                out_param1;
  logic [3:0]          out_param2;
  logic [3:0]          out_param3;
  logic [3:0]          out_param4;
  logic [ADDR_W:0]     out_index;
  // status
  logic                busy;
  logic                done;
  logic [ADDR_W:0]     emit_count;

  modport master (
    input  start, filter_en, filter_op, wr_ptr, wrapped, mem_rd_data, out_ready,
    output mem_rd_en, mem_rd_addr, out_valid, out_operator, out_param1,
           out_param2, out_param3, out_param4, out_index, busy, done, emit_count
  );

  modport slave (
    output start, filter_en, filter_op, wr_ptr, wrapped, mem_rd_data, out_ready,
    input  mem_rd_en, mem_rd_addr, out_valid, out_operator, out_param1,
           out_param2, out_param3, out_param4, out_index, busy, done, emit_count
  );
endinterface

`default_nettype wire

// File: rtl/machine_log_reader.sv
//------------------------------------------------------------------------------
// Module  : machine_log_reader
// Purpose : Replays the vending-machine log RAM oldest entry first, decoding
//           each 15-bit entry into operator/param fields, with an optional
//           operator-code filter.
// Ports   : clock, reset (synchronous, active-high)
//           bus (machine_log_reader_if.master):
//             start/filter_en/filter_op/wr_ptr/wrapped - replay control
//             mem_rd_en/mem_rd_addr/mem_rd_data        - log RAM read port
//             out_valid/out_ready/out_*/out_index      - decoded entry stream
//             busy/done/emit_count                     - status
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module machine_log_reader #(
  parameter int ADDR_W  = 4,
  parameter int ENTRY_W = 15
) (
  input wire logic              clock,
  input wire logic              reset,
  machine_log_reader_if.master  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q, num_d;     // entries in the snapshot
  logic [ADDR_W-1:0]   base_q, base_d;   // address of the oldest entry
  logic [CNT_W-1:0]    idx_q, idx_d;     // age index of current entry
  logic [CNT_W-1:0]    emit_q, emit_d;
  logic [ENTRY_W-1:0]  data_q, data_d;

  logic [CNT_W-1:0]    idx_inc;
  logic [ADDR_W-1:0]   rd_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      emit_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      emit_q  <= emit_d;
      data_q  <= data_d;
    end
  end

  // Truncation to ADDR_W bits gives the wrap from DEPTH-1 back to 0.
  assign rd_addr = base_q + idx_q[ADDR_W-1:0];
  assign idx_inc = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    base_d  = base_q;
    idx_d   = idx_q;
    emit_d  = emit_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Snapshot the writer state; later changes do not affect this replay.
          num_d   = bus.wrapped ? CNT_W'(DEPTH) : {1'b0, bus.wr_ptr};
          base_d  = bus.wrapped ? bus.wr_ptr : '0;
          idx_d   = '0;
          emit_d  = '0;
          state_d = (!bus.wrapped && (bus.wr_ptr == '0)) ? ST_FINISH : ST_READ;
        end
      end

      ST_READ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        data_d = bus.mem_rd_data;
        if (bus.filter_en && (bus.mem_rd_data[14:13] != bus.filter_op)) begin
          // Filtered-out entries are skipped without ever raising out_valid.
          idx_d   = idx_inc;
          state_d = (idx_inc == num_q) ? ST_FINISH : ST_READ;
        end else begin
          state_d = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (bus.out_ready) begin
          emit_d  = emit_q + CNT_W'(1);
          idx_d   = idx_inc;
          state_d = (idx_inc == num_q) ? ST_FINISH : ST_READ;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so reset clears them all.
  assign bus.mem_rd_en    = (state_q == ST_READ);
  assign bus.mem_rd_addr  = (state_q == ST_READ) ? rd_addr : '0;
  assign bus.out_valid    = (state_q == ST_PRESENT);
  assign bus.out_operator = data_q[14:13];
  assign bus.out_param1   = data_q[12];
  assign bus.out_param2   = data_q[11:8];
  assign bus.out_param3   = data_q[7:4];
  assign bus.out_param4   = data_q[3:0];
  assign bus.out_index    = idx_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_FINISH);
  assign bus.emit_count   = emit_q;

endmodule

`default_nettype wire

// File: tb/tb_machine_log_reader.sv
//------------------------------------------------------------------------------
// Module  : tb_machine_log_reader
// Purpose : Self-checking bench for machine_log_reader. A log RAM model answers
//           read strobes; a reference model computes, at replay start, the
//           expected read addresses, emitted entries and final count, which a
//           monitor compares against what the reader produces.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_machine_log_reader;

  localparam int ADDR_W  = 4;
  localparam int ENTRY_W = 15;
  localparam int DEPTH   = 16;

  logic clock;
  logic reset;

  machine_log_reader_if #(.ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W)) bus ();

  machine_log_reader #(.ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // log RAM model: data valid one cycle after the read strobe
  logic [ENTRY_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // consumer ready: 0 = held low, 1 = held high, 2 = random each cycle
  int ready_mode = 1;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard queues filled by the reference model
  logic [3:0]  exp_addr [$];
  logic [19:0] exp_out  [$];   // {entry[14:0], index[4:0]}
  logic [4:0]  exp_cnt  [$];

  // monitor
  int          done_cnt = 0;
  logic        stall = 1'b0;
  logic [19:0] prev_out;
  logic [19:0] cur_out;

  always @(negedge clock) begin
    cur_out = {bus.out_operator, bus.out_param1, bus.out_param2, bus.out_param3,
               bus.out_param4, bus.out_index};
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
        else check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_addr.pop_front()));
      end else begin
        check("rd_addr_idle", 32'(bus.mem_rd_addr), 0);
      end

      if (stall && !bus.out_valid) check("valid_dropped", 0, 1);
      if (stall && bus.out_valid) check("stall_stable", 32'(cur_out), 32'(prev_out));

      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) check("unexpected_entry", 1, 0);
        else check("entry", 32'(cur_out), 32'(exp_out.pop_front()));
      end else if (bus.out_valid && exp_out.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end
      stall    = bus.out_valid && !bus.out_ready;
      prev_out = cur_out;

      if (bus.done) begin
        if (exp_cnt.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("emit_count", 32'(bus.emit_count), 32'(exp_cnt.pop_front()));
          check("entries_left", 32'(exp_out.size()), 0);
          check("reads_left", 32'(exp_addr.size()), 0);
        end
        done_cnt++;
      end
    end
  end

  // Reference model: N/base from the writer state, then every entry oldest
  // first; entries failing the filter are read but not emitted.
  task automatic push_model(input logic [3:0] wp, input logic wr,
                            input logic fen, input logic [1:0] fop);
    int n, base, cnt;
    logic [3:0] a;
    logic [14:0] e;
    n    = wr ? DEPTH : int'(wp);
    base = wr ? int'(wp) : 0;
    cnt  = 0;
    for (int k = 0; k < n; k++) begin
      a = 4'((base + k) % DEPTH);
      exp_addr.push_back(a);
      e = mem[a];
      if (!fen || e[14:13] == fop) begin
        exp_out.push_back({e, 5'(k)});
        cnt++;
      end
    end
    exp_cnt.push_back(5'(cnt));
  endtask

  // Called right after a posedge (+#1); returns right after the start edge.
  task automatic begin_replay(input logic [3:0] wp, input logic wr,
                              input logic fen, input logic [1:0] fop);
    bus.wr_ptr    = wp;
    bus.wrapped   = wr;
    bus.filter_en = fen;
    bus.filter_op = fop;
    push_model(wp, wr, fen, fop);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    // writer keeps moving; the replay must use its snapshot
    bus.wr_ptr  = 4'($urandom);
    bus.wrapped = 1'($urandom);
  endtask

  task automatic wait_done(input int d0, output int cycles);
    cycles = 0;
    while (done_cnt == d0 && cycles < 500) begin
      @(posedge clock);
      cycles++;
    end
    #1;
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    while (!bus.out_valid && c < 50) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("valid_seen", 32'(bus.out_valid), 1);
  endtask

  int d0, cyc;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.filter_en = 1'b0;
    bus.filter_op = 2'd0;
    bus.wr_ptr    = '0;
    bus.wrapped   = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 32'({bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_operator,
          bus.out_param1, bus.out_param2, bus.out_param3, bus.out_param4, bus.out_index,
          bus.busy, bus.done, bus.emit_count}), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // empty log
    ready_mode = 1;
    d0 = done_cnt;
    begin_replay(4'd0, 1'b0, 1'b0, 2'd0);
    wait_done(d0, cyc);
    check("empty_done_latency", 32'(cyc <= 2), 1);

    // linear, with start-to-output latency
    mem[0] = {2'd0, 1'b1, 4'd2, 4'd5, 4'd1};
    mem[1] = {2'd1, 1'b1, 4'd2, 4'd5, 4'd1};
    mem[2] = {2'd2, 1'b1, 4'd2, 4'd5, 4'd1};
    d0 = done_cnt;
    begin_replay(4'd3, 1'b0, 1'b0, 2'd0);
    check("lat_rd_en", 32'(bus.mem_rd_en), 1);
    check("busy", 32'(bus.busy), 1);
    @(posedge clock);
    #1;
    check("lat_no_valid_yet", 32'(bus.out_valid), 0);
    @(posedge clock);
    #1;
    check("lat_valid", 32'(bus.out_valid), 1);
    wait_done(d0, cyc);
    check("linear_emit_count_hold", 32'(bus.emit_count), 3);
    check("idle_after_done", 32'(bus.busy), 0);

    // wrapped log starting at address 14
    for (int i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
    d0 = done_cnt;
    begin_replay(4'd14, 1'b1, 1'b0, 2'd0);
    wait_done(d0, cyc);
    check("wrap_emit_count", 32'(bus.emit_count), 16);

    // backpressure
    ready_mode = 0;
    d0 = done_cnt;
    begin_replay(4'd2, 1'b0, 1'b0, 2'd0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("bp_valid_held", 32'(bus.out_valid), 1);
    end
    ready_mode = 1;
    wait_done(d0, cyc);

    // filter on operator 3
    for (int i = 0; i < 4; i++) mem[i] = 15'($urandom);
    mem[0][14:13] = 2'd0;
    mem[1][14:13] = 2'd3;
    mem[2][14:13] = 2'd1;
    mem[3][14:13] = 2'd3;
    d0 = done_cnt;
    begin_replay(4'd4, 1'b0, 1'b1, 2'd3);
    wait_done(d0, cyc);
    check("filter_emit_count", 32'(bus.emit_count), 2);

    // randomized replays with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
      d0 = done_cnt;
      begin_replay(4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      wait_done(d0, cyc);
    end

    // reset in the middle of PRESENT aborts without done
    ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
    d0 = done_cnt;
    begin_replay(4'd5, 1'b0, 1'b0, 2'd0);
    wait_valid();
    reset = 1'b1;
    exp_addr.delete();
    exp_out.delete();
    exp_cnt.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_outputs", 32'({bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_operator,
          bus.out_param1, bus.out_param2, bus.out_param3, bus.out_param4, bus.out_index,
          bus.busy, bus.done, bus.emit_count}), 0);
    ready_mode = 1;
    repeat (6) @(posedge clock);
    #1;
    check("no_done_after_reset", 32'(done_cnt - d0), 0);
    check("idle_after_reset", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
